// File: rtl/reset_sequencer_pkg.sv
// Shared types for the boot/reset sequencer: state encoding (also driven out
// on seq_state for LEDs/debug), default timing constants and the output decode.
package reset_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_HOLD    = 3'd0,
    ST_SDINIT  = 3'd1,
    ST_HOSTRUN = 3'd2,
    ST_RUN     = 3'd3,
    ST_WARM    = 3'd4,
    ST_SOFT    = 3'd5,
    ST_PRESSED = 3'd6,
    ST_RECONF  = 3'd7
  } seq_state_t;

  localparam int SETTLE_CYCLES_DEF     = 4096;
  localparam int DEBOUNCE_CYCLES_DEF   = 65535;
  localparam int WARM_CYCLES_DEF       = 1024;
  localparam int LONG_PRESS_CYCLES_DEF = 16777215;
  localparam int CNT_W_DEF             = 24;

  typedef struct packed {
    logic sdram_n;
    logic host_n;
    logic main_n;
    logic reconf;
  } rst_out_t;

  function automatic rst_out_t state_outputs(seq_state_t s);
    rst_out_t o;
    o = '0;
    case (s)
      ST_HOLD:    o = '{sdram_n: 1'b0, host_n: 1'b0, main_n: 1'b0, reconf: 1'b0};
      ST_SDINIT:  o = '{sdram_n: 1'b1, host_n: 1'b0, main_n: 1'b0, reconf: 1'b0};
      ST_HOSTRUN: o = '{sdram_n: 1'b1, host_n: 1'b1, main_n: 1'b0, reconf: 1'b0};
      ST_RUN:     o = '{sdram_n: 1'b1, host_n: 1'b1, main_n: 1'b1, reconf: 1'b0};
      ST_WARM:    o = '{sdram_n: 1'b1, host_n: 1'b0, main_n: 1'b0, reconf: 1'b0};
      ST_SOFT:    o = '{sdram_n: 1'b1, host_n: 1'b1, main_n: 1'b0, reconf: 1'b0};
      ST_PRESSED: o = '{sdram_n: 1'b1, host_n: 1'b0, main_n: 1'b0, reconf: 1'b0};
      ST_RECONF:  o = '{sdram_n: 1'b1, host_n: 1'b0, main_n: 1'b0, reconf: 1'b1};
      default:    o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Reset button conditioning: 2-flop synchroniser, stability counter and
// single-cycle registered press/release events on debounced edges.
module button_debounce
  import reset_sequencer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic n_reset,
  input  logic button_n,
  output logic press_ev,
  output logic release_ev
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic          deb_q;
  logic          flip;

  // Nth consecutive sample disagreeing with the debounced level
  assign flip = (sync_q[1] != deb_q) && (cnt_q == LAST);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      sync_q     <= 2'b11;
      cnt_q      <= '0;
      deb_q      <= 1'b1;
      press_ev   <= 1'b0;
      release_ev <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], button_n};
      if (sync_q[1] == deb_q || flip) cnt_q <= '0;
      else                            cnt_q <= cnt_q + CW'(1);
      if (flip) deb_q <= sync_q[1];
      press_ev   <= flip & deb_q;
      release_ev <= flip & ~deb_q;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Boot/reset sequencer: SDRAM first, then host CPU, then main 68k on host
// release; button gives warm reset (short) or reconfiguration (long).
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int SETTLE_CYCLES     = SETTLE_CYCLES_DEF,
  parameter int DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_DEF,
  parameter int WARM_CYCLES       = WARM_CYCLES_DEF,
  parameter int LONG_PRESS_CYCLES = LONG_PRESS_CYCLES_DEF,
  parameter int CNT_W             = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       button_n,
  input  logic       sdram_ready,
  input  logic       host_release_main,
  input  logic       soft_reset_req,
  output logic       sdram_reset_n,
  output logic       host_reset_n,
  output logic       main_reset_n,
  output logic       reconfigure,
  output logic [2:0] seq_state
);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WARM_LAST   = CNT_W'(WARM_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_PRESS_CYCLES - 1);

  seq_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  rst_out_t         out_q;
  logic             press_ev, release_ev;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
    .clk        (clk),
    .n_reset    (n_reset),
    .button_n   (button_n),
    .press_ev   (press_ev),
    .release_ev (release_ev)
  );

  // Outputs decoded from the current state and registered: glitch-free, one cycle behind
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= ST_HOLD;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= state_outputs(state_q);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HOLD:
        if (cnt_q == SETTLE_LAST) state_d = ST_SDINIT;
      ST_SDINIT:
        if (sdram_ready) state_d = ST_HOSTRUN;
      ST_HOSTRUN:
        if (!sdram_ready)           state_d = ST_HOLD;
        else if (press_ev)          state_d = ST_PRESSED;
        else if (host_release_main) state_d = ST_RUN;
      ST_RUN:
        if (!sdram_ready)            state_d = ST_HOLD;
        else if (press_ev)           state_d = ST_PRESSED;
        else if (soft_reset_req)     state_d = ST_SOFT;
        else if (!host_release_main) state_d = ST_HOSTRUN;
      ST_WARM:
        if (!sdram_ready)           state_d = ST_HOLD;
        else if (cnt_q == WARM_LAST) state_d = ST_HOSTRUN;
      ST_SOFT:
        if (!sdram_ready)            state_d = ST_HOLD;
        else if (press_ev)           state_d = ST_PRESSED;
        else if (cnt_q == WARM_LAST) state_d = host_release_main ? ST_RUN : ST_HOSTRUN;
      ST_PRESSED:
        if (!sdram_ready)            state_d = ST_HOLD;
        else if (release_ev)         state_d = ST_WARM;
        else if (cnt_q == LONG_LAST) state_d = ST_RECONF;
      ST_RECONF:
        state_d = ST_RECONF;
      default:
        state_d = ST_HOLD;
    endcase
  end

  // Cleared on state entry, saturating otherwise
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) cnt_d = '0;
    else if (!(&cnt_q))     cnt_d = cnt_q + CNT_W'(1);
  end

  assign sdram_reset_n = out_q.sdram_n;
  assign host_reset_n  = out_q.host_n;
  assign main_reset_n  = out_q.main_n;
  assign reconfigure   = out_q.reconf;
  assign seq_state     = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed + randomized bench for reset_sequencer against a cycle-level
// behavioural model (delay line + run-length debounce + dwell-time sequencer).
module tb_reset_sequencer;

  localparam int SETTLE = 8;
  localparam int DEB    = 4;
  localparam int WARM   = 6;
  localparam int LONG   = 40;
  localparam int CW     = 8;

  logic       clk = 1'b0;
  logic       n_reset, button_n, sdram_ready, host_release_main, soft_reset_req;
  logic       sdram_reset_n, host_reset_n, main_reset_n, reconfigure;
  logic [2:0] seq_state;

  int    total = 0;
  int    bad   = 0;
  string phase = "init";

  always #5 clk = ~clk;

  reset_sequencer #(
    .SETTLE_CYCLES(SETTLE), .DEBOUNCE_CYCLES(DEB), .WARM_CYCLES(WARM),
    .LONG_PRESS_CYCLES(LONG), .CNT_W(CW)
  ) dut (
    .clk(clk), .n_reset(n_reset), .button_n(button_n), .sdram_ready(sdram_ready),
    .host_release_main(host_release_main), .soft_reset_req(soft_reset_req),
    .sdram_reset_n(sdram_reset_n), .host_reset_n(host_reset_n),
    .main_reset_n(main_reset_n), .reconfigure(reconfigure), .seq_state(seq_state)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  // ---- reference model ----
  // {sdram_n, host_n, main_n, reconf} for each state number 0..7
  bit [3:0] out_tab [8] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110,
                            4'b1000, 4'b1100, 4'b1000, 4'b1001};
  int       m_st, m_age, m_run;
  bit       m_deb, m_press, m_release;
  bit       dly_q[$];
  bit [3:0] m_out;

  task automatic model_reset();
    m_st = 0; m_age = 0; m_run = 0;
    m_deb = 1'b1; m_press = 1'b0; m_release = 1'b0;
    dly_q = '{1'b1, 1'b1};
    m_out = 4'b0000;
  endtask

  task automatic model_step();
    int nx;
    bit s;
    nx = m_st;
    case (m_st)
      0: if (m_age == SETTLE - 1) nx = 1;
      1: if (sdram_ready) nx = 2;
      2: if (!sdram_ready) nx = 0; else if (m_press) nx = 6; else if (host_release_main) nx = 3;
      3: if (!sdram_ready) nx = 0; else if (m_press) nx = 6;
         else if (soft_reset_req) nx = 5; else if (!host_release_main) nx = 2;
      4: if (!sdram_ready) nx = 0; else if (m_age == WARM - 1) nx = 2;
      5: if (!sdram_ready) nx = 0; else if (m_press) nx = 6;
         else if (m_age == WARM - 1) nx = host_release_main ? 3 : 2;
      6: if (!sdram_ready) nx = 0; else if (m_release) nx = 4; else if (m_age == LONG - 1) nx = 7;
      default: ;
    endcase
    m_out = out_tab[m_st];
    m_age = (nx != m_st) ? 0 : m_age + 1;
    m_st  = nx;
    // button: two-sample delay, then DEB consecutive disagreeing samples flip the level
    s = dly_q.pop_front();
    dly_q.push_back(button_n);
    m_press = 1'b0; m_release = 1'b0;
    if (s != m_deb) begin
      m_run++;
      if (m_run == DEB) begin
        m_deb = s; m_run = 0; m_press = !s; m_release = s;
      end
    end else m_run = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk({phase, "/out"}, {sdram_reset_n, host_reset_n, main_reset_n, reconfigure}, m_out);
    chk({phase, "/st"}, seq_state, m_st);
  endtask

  // called ~1 time unit after an edge; asserts reset between edges
  task automatic async_reset(input int hold);
    #2 n_reset = 1'b0;
    #1 chk({phase, "/async"}, {sdram_reset_n, host_reset_n, main_reset_n, reconfigure, seq_state}, 0);
    model_reset();
    repeat (hold) @(posedge clk);
    #1 chk({phase, "/inrst"}, {sdram_reset_n, host_reset_n, main_reset_n, reconfigure, seq_state}, 0);
    n_reset = 1'b1;
  endtask

  task automatic run_until(input int target, input int limit);
    int n = 0;
    while (m_st != target && n < limit) begin tick(); n++; end
    chk({phase, "/reach"}, seq_state, target);
  endtask

  task automatic bring_up();
    async_reset(2);
    sdram_ready = 1'b1; host_release_main = 1'b1;
    run_until(3, 40);
  endtask

  initial begin
    int sd_rise, host_rise, main_rise, n_warm, sd_low, n_main_low, host_low, rc, n, lvl_left;
    n_reset = 1'b0; button_n = 1'b1; sdram_ready = 1'b0;
    host_release_main = 1'b0; soft_reset_req = 1'b0;
    model_reset();
    @(posedge clk);
    #1 chk("rst", {sdram_reset_n, host_reset_n, main_reset_n, reconfigure, seq_state}, 0);
    @(posedge clk);
    #1 n_reset = 1'b1;

    // power-up ordering
    phase = "pwr";
    sd_rise = -1; host_rise = -1; main_rise = -1;
    for (int c = 1; c <= 40; c++) begin
      if (c >= 20) sdram_ready = 1'b1;
      if (c >= 30) host_release_main = 1'b1;
      tick();
      if (sd_rise < 0 && sdram_reset_n) sd_rise = c;
      if (host_rise < 0 && host_reset_n) host_rise = c;
      if (main_rise < 0 && main_reset_n) main_rise = c;
    end
    chk("pwr_sd_rise", sd_rise, SETTLE + 1);
    chk("pwr_host_rise", host_rise, 21);
    chk("pwr_main_rise", main_rise, 31);

    // bounce shorter than the debounce window
    phase = "bounce";
    button_n = 1'b0;
    repeat (3) tick();
    button_n = 1'b1;
    repeat (10) tick();
    chk("bounce_st", seq_state, 3);

    // short press
    phase = "short";
    n_warm = 0; sd_low = 0;
    button_n = 1'b0;
    repeat (20) begin tick(); if (seq_state == 3'd4) n_warm++; if (!sdram_reset_n) sd_low++; end
    button_n = 1'b1; host_release_main = 1'b0;
    repeat (40) begin tick(); if (seq_state == 3'd4) n_warm++; if (!sdram_reset_n) sd_low++; end
    chk("short_warm_len", n_warm, WARM);
    chk("short_sd_held", sd_low, 0);
    chk("short_main_held", main_reset_n, 0);
    host_release_main = 1'b1;
    repeat (3) tick();
    chk("short_main_up", main_reset_n, 1);

    // soft reset, second request during SOFT ignored
    phase = "soft";
    n_main_low = 0; host_low = 0;
    soft_reset_req = 1'b1;
    tick();
    soft_reset_req = 1'b0;
    for (int c = 0; c < 20; c++) begin
      soft_reset_req = (c == 2);
      tick();
      if (!main_reset_n) n_main_low++;
      if (!host_reset_n) host_low++;
    end
    soft_reset_req = 1'b0;
    chk("soft_main_low", n_main_low, WARM);
    chk("soft_host_low", host_low, 0);

    // press and soft request in the same cycle
    phase = "both";
    button_n = 1'b0;
    n = 0;
    while (!m_press && n < 12) begin tick(); n++; end
    soft_reset_req = 1'b1;
    tick();
    soft_reset_req = 1'b0;
    chk("press_wins", seq_state, 6);
    button_n = 1'b1;
    run_until(3, 60);

    // SDRAM loss in RUN forces full cold restart
    phase = "sdfault";
    sdram_ready = 1'b0;
    repeat (2) tick();
    chk("fault_rst", {sdram_reset_n, host_reset_n, main_reset_n}, 0);
    sdram_ready = 1'b1;
    run_until(3, 40);

    // async reset in the middle of WARM
    phase = "warmrst";
    button_n = 1'b0;
    repeat (12) tick();
    button_n = 1'b1;
    run_until(4, 30);
    tick();
    chk("warm_before_rst", seq_state, 4);
    async_reset(2);
    bring_up();

    // long press -> sticky reconfigure
    phase = "long";
    rc = -1;
    button_n = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      tick();
      if (rc < 0 && reconfigure) rc = c;
    end
    chk("long_reconf_at", rc, 2 + DEB + 1 + LONG + 1);
    button_n = 1'b1;
    repeat (20) tick();
    chk("long_sticky", reconfigure, 1);
    sdram_ready = 1'b0;
    repeat (3) tick();
    chk("long_sd_ignored", seq_state, 7);
    sdram_ready = 1'b1;
    async_reset(1);

    // randomized traffic
    phase = "rand";
    lvl_left = 0;
    for (int i = 0; i < 5000; i++) begin
      if (lvl_left == 0) begin
        button_n = ~button_n;
        lvl_left = int'($urandom_range(1, 60));
      end
      lvl_left--;
      soft_reset_req = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 49) == 0) host_release_main = ~host_release_main;
      if (!sdram_ready) sdram_ready = ($urandom_range(0, 3) == 0);
      else              sdram_ready = ($urandom_range(0, 399) != 0);
      if ($urandom_range(0, 999) == 0) async_reset(1);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
